// File: rtl/cfg_req_rr_arbiter_pkg.sv
// Shared config-bus types for the 32-bit config request arbiter.
// Request/ack bundles, arbiter states and small decode helpers.
package cfg_req_rr_arbiter_pkg;

    typedef enum logic [3:0] {
        MRD   = 4'h0,
        MWR   = 4'h1,
        IORD  = 4'h2,
        IOWR  = 4'h3,
        CFGRD = 4'h4,
        CFGWR = 4'h5,
        CRRD  = 4'h6,
        CRWR  = 4'h7
    } cfg_opcode_t;

    // 108 bits: valid + opcode + 48b addr + be + data + sai + fid + bar
    typedef struct packed {
        logic        valid;
        cfg_opcode_t opcode;
        logic [47:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [7:0]  sai;
        logic [7:0]  fid;
        logic [2:0]  bar;
    } cfg_req_32bit_t;

    // 37 bits: four completion flags + sai status + read data
    typedef struct packed {
        logic        read_valid;
        logic        read_miss;
        logic        write_valid;
        logic        write_miss;
        logic        sai_successfull;
        logic [31:0] data;
    } cfg_ack_32bit_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    function automatic logic f_cfg_ack_done(input cfg_ack_32bit_t a);
        return a.read_valid | a.read_miss | a.write_valid | a.write_miss;
    endfunction

    function automatic logic f_cfg_is_read(input cfg_opcode_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/cfg_rr_pick.sv
// Combinational round-robin picker: first valid index at or above
// ptr_i, wrapping modulo N.
module cfg_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] winner_o,
    output logic                 any_valid_o
);

    localparam int W = $clog2(N);

    int idx;

    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!any_valid_o && valid_i[idx[W-1:0]]) begin
                winner_o    = idx[W-1:0];
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_req_rr_arbiter.sv
// Round-robin share of one 32-bit config target between N_REQ masters,
// one transaction at a time, with a timeout for a hung target.
module cfg_req_rr_arbiter
    import cfg_req_rr_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  cfg_req_32bit_t           req_in [N_REQ],
    output cfg_ack_32bit_t           ack_out [N_REQ],
    output cfg_req_32bit_t           tgt_req,
    input  cfg_ack_32bit_t           tgt_ack,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     timeout_pulse,
    output logic                     stray_ack_pulse
);

    localparam int GW   = $clog2(N_REQ);
    localparam int TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    arb_state_t     state_q, state_d;
    logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    cfg_req_32bit_t tgt_q, tgt_d;
    cfg_ack_32bit_t ack_q [N_REQ];
    cfg_ack_32bit_t ack_d [N_REQ];

    logic [N_REQ-1:0] req_valid;
    logic [GW-1:0]    win;
    logic             any_valid;
    logic             done;
    logic             to_fire;
    cfg_ack_32bit_t   syn_ack;

    always_comb begin
        req_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i] = req_in[i].valid;
        end
    end

    cfg_rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .valid_i     (req_valid),
        .ptr_i       (rr_ptr_q),
        .winner_o    (win),
        .any_valid_o (any_valid)
    );

    assign done = f_cfg_ack_done(tgt_ack);

    // Miss flavour follows the opcode of the transaction still on the bus
    always_comb begin
        syn_ack            = '0;
        syn_ack.read_miss  = f_cfg_is_read(tgt_q.opcode);
        syn_ack.write_miss = ~f_cfg_is_read(tgt_q.opcode);
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        ack_d    = ack_q;
        to_fire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    tgt_d       = req_in[win];
                    tgt_d.valid = 1'b1;
                    grant_d     = win;
                    rr_ptr_d    = (win == GW'(N_REQ - 1)) ? '0 : win + 1'b1;
                    cnt_d       = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (TO_EN) cnt_d = cnt_q + 1'b1;
                // A real ack beats a timeout expiring in the same cycle
                if (done) begin
                    ack_d[grant_q] = tgt_ack;
                    tgt_d.valid    = 1'b0;
                    state_d        = RESP;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    ack_d[grant_q] = syn_ack;
                    to_fire        = 1'b1;
                    tgt_d.valid    = 1'b0;
                    state_d        = RESP;
                end
            end
            RESP: begin
                ack_d   = '{default: '0};
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            tgt_q    <= '0;
            ack_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            ack_q    <= ack_d;
        end
    end

    assign ack_out         = ack_q;
    assign tgt_req         = tgt_q;
    assign busy            = (state_q != IDLE);
    assign grant_id        = grant_q;
    assign timeout_pulse   = to_fire;
    assign stray_ack_pulse = done && (state_q != ISSUE);

    always_ff @(posedge clk) begin
        if (!rst && state_q == ISSUE)
            assert (req_in[grant_q].valid)
            else $error("cfg_req_rr_arbiter: requester %0d dropped valid while granted", grant_q);
    end

endmodule

// File: tb/tb_cfg_req_rr_arbiter.sv
// Directed bench for cfg_req_rr_arbiter (N_REQ=4, TIMEOUT_CYC=16).
// Inputs change and outputs are sampled 1-2 time units after posedge.
module tb_cfg_req_rr_arbiter;
    import cfg_req_rr_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    cfg_req_32bit_t req [N];
    cfg_ack_32bit_t ack [N];
    cfg_req_32bit_t treq;
    cfg_ack_32bit_t tack;
    logic           busy;
    logic [1:0]     gid;
    logic           top;
    logic           sap;

    int npass = 0;
    int ntot  = 0;
    int vcnt;

    always #5 clk = ~clk;

    cfg_req_rr_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_in          (req),
        .ack_out         (ack),
        .tgt_req         (treq),
        .tgt_ack         (tack),
        .busy            (busy),
        .grant_id        (gid),
        .timeout_pulse   (top),
        .stray_ack_pulse (sap)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic cfg_req_32bit_t mkreq(input cfg_opcode_t op, input logic [47:0] a,
                                             input logic [31:0] d);
        cfg_req_32bit_t r;
        r        = '0;
        r.valid  = 1'b1;
        r.opcode = op;
        r.addr   = a;
        r.be     = 4'hF;
        r.data   = d;
        r.sai    = 8'h5A;
        r.fid    = 8'h01;
        return r;
    endfunction

    function automatic cfg_ack_32bit_t mkack(input bit rv, input bit rm, input bit wv,
                                             input bit wm, input bit s, input logic [31:0] d);
        cfg_ack_32bit_t a;
        a.read_valid      = rv;
        a.read_miss       = rm;
        a.write_valid     = wv;
        a.write_miss      = wm;
        a.sai_successfull = s;
        a.data            = d;
        return a;
    endfunction

    task automatic chk_acks(input string tag, input int owner, input cfg_ack_32bit_t e);
        cfg_ack_32bit_t x;
        for (int i = 0; i < N; i++) begin
            x = '0;
            if (i == owner) x = e;
            chk($sformatf("%s_ack%0d", tag, i), ack[i], x);
        end
    endtask

    // Starts in an IDLE cycle with requests set; ends in the IDLE after RESP
    task automatic txn(input string tag, input int g, input int d, input cfg_ack_32bit_t ta);
        cyc();
        chk({tag, "_gid"}, gid, g);
        chk({tag, "_treq"}, treq, req[g]);
        for (int i = 0; i < d; i++) cyc();
        tack = ta;
        #1;
        chk({tag, "_pulses"}, {top, sap}, 2'b00);
        cyc();
        tack = '0;
        chk({tag, "_resp_tvalid"}, treq.valid, 1'b0);
        chk({tag, "_resp_busy"}, busy, 1'b1);
        chk_acks({tag, "_resp"}, g, ta);
        cyc();
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk_acks({tag, "_idle"}, -1, '0);
    endtask

    initial begin
        rst  = 1'b1;
        tack = '0;
        for (int i = 0; i < N; i++) req[i] = '0;
        cyc();
        cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_gid", gid, 2'd0);
        chk("rst_treq", treq, 108'd0);
        chk("rst_pulses", {top, sap}, 2'b00);
        chk("rst_rr", dut.rr_ptr_q, 2'd0);
        chk_acks("rst", -1, '0);
        rst = 1'b0;

        // Single read, target answers in the 4th ISSUE cycle
        req[0] = mkreq(CRRD, 48'h0000_0000_0040, 32'h0);
        #1;
        chk("t1_no_passthru", treq.valid, 1'b0);
        vcnt = 0;
        for (int c = 0; c < 7; c++) begin
            cyc();
            tack = '0;
            if (treq.valid) vcnt++;
            if (c == 0) chk("t1_gid", gid, 2'd0);
            if (c == 0) chk("t1_treq", treq, req[0]);
            if (c == 3) tack = mkack(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
            if (c == 4) chk_acks("t1_resp", 0, mkack(1, 0, 0, 0, 1, 32'hDEAD_BEEF));
            if (c == 5) begin
                chk_acks("t1_clear", -1, '0);
                req[0].valid = 1'b0;
            end
            if (c == 6) chk("t1_idle_busy", busy, 1'b0);
        end
        chk("t1_valid_cycles", vcnt, 4);

        // All four continuously valid from reset
        rst = 1'b1;
        for (int i = 0; i < N; i++)
            req[i] = mkreq((i % 2 == 0) ? CRRD : MWR, 48'h100 * (i + 1), 32'hA0 + i);
        cyc();
        cyc();
        chk("t2_rst_rr", dut.rr_ptr_q, 2'd0);
        rst = 1'b0;
        txn("t2a", 0, 0, mkack(1, 0, 0, 0, 1, 32'h1111_0000));
        txn("t2b", 1, 1, mkack(0, 0, 1, 0, 1, 32'h0));
        txn("t2c", 2, 2, mkack(0, 1, 0, 0, 0, 32'h0));
        txn("t2d", 3, 0, mkack(0, 0, 0, 1, 1, 32'h0));
        txn("t2e", 0, 1, mkack(1, 0, 0, 0, 1, 32'h2222_0000));
        for (int i = 0; i < N; i++) req[i].valid = 1'b0;

        // Move pointer to 2, then 1 and 3 compete
        req[1] = mkreq(CRWR, 48'h0000_1234_0000, 32'h5555);
        txn("t6pre", 1, 0, mkack(0, 0, 1, 0, 1, 32'h0));
        chk("t6_rr_start", dut.rr_ptr_q, 2'd2);
        req[3] = mkreq(CRRD, 48'h0000_3333_0000, 32'h0);
        txn("t6a", 3, 1, mkack(1, 0, 0, 0, 1, 32'h3333_3333));
        req[3].valid = 1'b0;
        txn("t6b", 1, 0, mkack(0, 0, 1, 0, 1, 32'h0));
        req[1].valid = 1'b0;
        chk("t6_rr_end", dut.rr_ptr_q, 2'd2);

        // Silent target: write times out in ISSUE cycle 16
        req[2] = mkreq(MWR, 48'h0000_0000_0800, 32'hCAFE_F00D);
        for (int k = 1; k <= TO; k++) begin
            cyc();
            chk($sformatf("t3_top_c%0d", k), top, (k == TO));
            if (k == 1 || k == TO) chk("t3_tvalid", treq.valid, 1'b1);
        end
        cyc();
        chk("t3_resp_top", top, 1'b0);
        chk("t3_resp_tvalid", treq.valid, 1'b0);
        chk_acks("t3_resp", 2, mkack(0, 0, 0, 1, 0, 32'h0));
        cyc();
        req[2].valid = 1'b0;
        chk_acks("t3_idle", -1, '0);
        cyc();
        cyc();
        cyc();
        tack = mkack(0, 0, 1, 0, 1, 32'h0);
        #1;
        chk("t3_stray", sap, 1'b1);
        chk("t3_stray_busy", busy, 1'b0);
        cyc();
        tack = '0;
        #1;
        chk("t3_stray_gone", sap, 1'b0);
        chk("t3_after_busy", busy, 1'b0);
        chk_acks("t3_after", -1, '0);

        // Real ack arrives exactly on the expiry cycle
        req[0] = mkreq(CRRD, 48'h0000_0000_0044, 32'h0);
        for (int k = 1; k <= TO; k++) begin
            cyc();
            if (k == TO) begin
                tack = mkack(1, 0, 0, 0, 1, 32'h1234_5678);
                #1;
            end
            chk($sformatf("t4_top_c%0d", k), top, 1'b0);
        end
        cyc();
        tack = '0;
        chk("t4_resp_top", top, 1'b0);
        chk_acks("t4_resp", 0, mkack(1, 0, 0, 0, 1, 32'h1234_5678));
        cyc();
        req[0].valid = 1'b0;

        // Reset in the second ISSUE cycle
        req[0] = mkreq(CRRD, 48'h0000_0000_0050, 32'h0);
        req[2] = mkreq(CRWR, 48'h0000_0000_0060, 32'h7777);
        cyc();
        chk("t5_pre_gid", gid, 2'd2);
        cyc();
        rst = 1'b1;
        cyc();
        chk("t5_tvalid", treq.valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_rr", dut.rr_ptr_q, 2'd0);
        chk("t5_gid", gid, 2'd0);
        chk_acks("t5_rst", -1, '0);
        rst = 1'b0;
        txn("t5a", 0, 0, mkack(1, 0, 0, 0, 1, 32'h0BAD_F00D));
        req[0].valid = 1'b0;
        txn("t5b", 2, 1, mkack(0, 0, 1, 0, 1, 32'h0));
        req[2].valid = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
